// File: rtl/dram_read_path_buffer.sv
// Elastic first-word-fall-through buffer for one ORAM path of DRAM read bursts.
// Debug mode holds back all output until a whole path has been received.
module dram_read_path_buffer #(
  parameter int Width           = 512,
  parameter int Depth           = 64,
  parameter int DebugReadTiming = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [Width-1:0] InData,
  input  logic             InValid,
  output logic             InAccept,
  output logic [Width-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);
  localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_raw_valid;
  logic w_gate_open;
  logic w_push;
  logic w_pop;

  assign w_raw_valid = (r_count != '0);
  assign InAccept    = (r_count != FULL_CNT);
  assign w_push      = InValid & InAccept;
  assign OutValid    = w_raw_valid & w_gate_open;
  assign w_pop       = OutValid & OutReady;
  assign OutData     = r_mem[r_rptr];

  // Storage carries no reset; the occupancy count alone decides what is live.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= InData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Gate opens once Depth beats (dropped ones included) have been seen, and
  // re-arms the cycle after the buffer drains.
  if (DebugReadTiming != 0) begin : g_gate
    logic          r_started;
    logic [CW-1:0] r_beat_cnt;
    logic          w_stopped;

    assign w_stopped   = r_started & ~w_raw_valid;
    assign w_gate_open = (r_beat_cnt == FULL_CNT);

    always_ff @(posedge Clock) begin
      if (Reset || w_stopped) begin
        r_started  <= 1'b0;
        r_beat_cnt <= '0;
      end else begin
        if (w_raw_valid) begin
          r_started <= 1'b1;
        end
        if (InValid && (r_beat_cnt != FULL_CNT)) begin
          r_beat_cnt <= r_beat_cnt + CW'(1);
        end
      end
    end
  end else begin : g_nogate
    assign w_gate_open = 1'b1;
  end

endmodule

// File: tb/tb_dram_read_path_buffer.sv
// Directed bench: normal Depth=4, normal Depth=3 and debug-gated Depth=4 instances.
module tb_dram_read_path_buffer;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  int           n_checks;
  int           n_errors;

  logic [W-1:0] a_in,  b_in,  c_in;
  logic         a_iv,  b_iv,  c_iv;
  logic         a_acc, b_acc, c_acc;
  logic [W-1:0] a_out, b_out, c_out;
  logic         a_ov,  b_ov,  c_ov;
  logic         a_rdy, b_rdy, c_rdy;

  dram_read_path_buffer #(.Width(W), .Depth(4), .DebugReadTiming(0)) u_norm (
    .Clock(clk), .Reset(rst), .InData(a_in), .InValid(a_iv), .InAccept(a_acc),
    .OutData(a_out), .OutValid(a_ov), .OutReady(a_rdy));

  dram_read_path_buffer #(.Width(W), .Depth(3), .DebugReadTiming(0)) u_wrap (
    .Clock(clk), .Reset(rst), .InData(b_in), .InValid(b_iv), .InAccept(b_acc),
    .OutData(b_out), .OutValid(b_ov), .OutReady(b_rdy));

  dram_read_path_buffer #(.Width(W), .Depth(4), .DebugReadTiming(1)) u_dbg (
    .Clock(clk), .Reset(rst), .InData(c_in), .InValid(c_iv), .InAccept(c_acc),
    .OutData(c_out), .OutValid(c_ov), .OutReady(c_rdy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] nxt;
    logic         do_push, do_pop;
    int           pushed, popped;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a_in = '0; a_iv = 0; a_rdy = 0;
    b_in = '0; b_iv = 0; b_rdy = 0;
    c_in = '0; c_iv = 0; c_rdy = 0;
    #2;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_ov",  a_ov,  0);
    check_val("rst_acc", a_acc, 1);
    check_val("rst_dbg_ov", c_ov, 0);

    // Fill to full with OutReady low
    for (int i = 0; i < 4; i++) begin
      a_in = W'(16'hD0 + i); a_iv = 1;
      tick();
      if (i == 0) begin
        check_val("lat_ov",   a_ov,  1);
        check_val("lat_data", a_out, 16'hD0);
      end
    end
    check_val("full_acc", a_acc, 0);
    a_in = 16'hD4;            // dropped
    tick();
    check_val("drop_acc", a_acc, 0);
    a_iv = 0;

    // Drain; a beat offered during the first pop at full is also dropped
    a_rdy = 1;
    a_in = 16'hD5; a_iv = 1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_ov",   a_ov,  1);
      check_val("drain_data", a_out, W'(16'hD0 + i));
      tick();
      a_iv = 0;
      if (i == 0) check_val("slot_free_acc", a_acc, 1);
    end
    check_val("drain_empty", a_ov, 0);

    // Streaming 1..20 with OutReady high
    for (int v = 1; v <= 20; v++) begin
      a_in = W'(v); a_iv = 1;
      tick();
      check_val("stream_ov",   a_ov,  1);
      check_val("stream_data", a_out, v);
      check_val("stream_acc",  a_acc, 1);
    end
    a_iv = 0;
    tick();
    check_val("stream_end", a_ov, 0);
    a_rdy = 0;

    // Wrap-around on Depth=3 with random handshakes against a queue model
    nxt = 16'h100;
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      b_iv  = (pushed < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_rdy = 1'($urandom_range(0, 1));
      b_in  = nxt;
      check_val("wrap_ov",  b_ov,  (q.size() != 0) ? 1 : 0);
      check_val("wrap_acc", b_acc, (q.size() < 3) ? 1 : 0);
      if (q.size() != 0) check_val("wrap_data", b_out, q[0]);
      do_push = b_iv && (q.size() < 3);
      do_pop  = b_rdy && (q.size() != 0);
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(nxt);
        nxt = nxt + 1'b1;
        pushed++;
      end
    end
    b_iv = 0;
    b_rdy = 1;
    for (int k = 0; k < 8 && q.size() != 0; k++) begin
      check_val("wrap_tail_data", b_out, q[0]);
      tick();
      void'(q.pop_front());
      popped++;
    end
    check_val("wrap_all_out", popped, pushed);
    check_val("wrap_final_ov", b_ov, 0);
    b_rdy = 0;

    // Debug gating: two paths of 4 beats each
    c_rdy = 1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        c_in = W'(16'h31 + 16'h10 * p + i); c_iv = 1;
        tick();
        check_val((i < 3) ? "dbg_hold_ov" : "dbg_open_ov", c_ov, (i < 3) ? 0 : 1);
      end
      c_iv = 0;
      for (int i = 0; i < 4; i++) begin
        check_val("dbg_drain_ov",   c_ov,  1);
        check_val("dbg_drain_data", c_out, 16'h31 + 16'h10 * p + i);
        tick();
      end
      check_val("dbg_empty_ov", c_ov, 0);
      tick();
      tick();
    end
    c_rdy = 0;

    // Reset mid-fill, normal mode
    a_in = 16'hE1; a_iv = 1; tick();
    a_in = 16'hE2; tick();
    a_iv = 0;
    rst = 1; tick(); rst = 0;
    check_val("midrst_ov", a_ov, 0);
    a_in = 16'hAA; a_iv = 1; tick();
    a_in = 16'hBB; tick();
    a_iv = 0;
    a_rdy = 1;
    check_val("midrst_a", a_out, 16'hAA);
    tick();
    check_val("midrst_b_ov", a_ov, 1);
    check_val("midrst_b", a_out, 16'hBB);
    tick();
    check_val("midrst_end", a_ov, 0);
    a_rdy = 0;

    // Reset mid-fill, debug mode: beat count must restart from zero
    c_rdy = 1;
    c_in = 16'hE1; c_iv = 1; tick();
    c_in = 16'hE2; tick();
    c_iv = 0;
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      c_in = W'(16'hA0 + i); c_iv = 1;
      tick();
      check_val((i < 3) ? "dbg_rst_hold" : "dbg_rst_open", c_ov, (i < 3) ? 0 : 1);
    end
    c_iv = 0;
    for (int i = 0; i < 4; i++) begin
      check_val("dbg_rst_data", c_out, 16'hA0 + i);
      tick();
    end
    check_val("dbg_rst_end", c_ov, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
